// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Optional first-word fall-through read port selected by defining SYNC_FIFO_FWFT_EN.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     clr_err,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance: a full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc     = rd_en && !empty;
    wr_acc     = wr_en && (!full || rd_acc);
    count_nxt  = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    wr_ptr_nxt = wr_acc ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_nxt = rd_acc ? rd_ptr + PTR_W'(1) : rd_ptr;
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Pointers, occupancy and status flags decoded from the next count so they move with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= (count_nxt == CNT_W'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CNT_W'(AF_THRESH));
      almost_empty <= (count_nxt <= CNT_W'(AE_THRESH));
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && !rd_acc) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head-of-queue register: tracks mem[rd_ptr], forwarding a write that lands on the new head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (count_nxt == '0) begin
      rd_data <= '0;
    end else if (wr_acc && (wr_ptr == rd_ptr_nxt)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_ptr_nxt[ADDR_W-1:0]];
    end
  end
`else
  // Registered read: one-cycle latency, holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_acc) begin
      rd_data <= mem[rd_ptr[ADDR_W-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: two independent channels (16x8 and 4x32) on one clock.
module tb_sync_fifo_param;

  logic        clk;
  logic        rst_n;
  logic        wr_en0, rd_en0, clr0;
  logic [7:0]  wr_data0, rd_data0;
  logic        full0, empty0, af0, ae0, ovf0, unf0;
  logic [4:0]  count0;
  logic        wr_en1, rd_en1, clr1;
  logic [31:0] wr_data1, rd_data1;
  logic        full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0]  count1;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
    .rd_data(rd_data0), .clr_err(clr0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.DATA_W(32), .DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
    .rd_data(rd_data1), .clr_err(clr1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic we0, input logic [7:0] wd0, input logic re0, input logic ce0,
                     input logic we1, input logic [31:0] wd1, input logic re1);
    wr_en0 = we0; wr_data0 = wd0; rd_en0 = re0; clr0 = ce0;
    wr_en1 = we1; wr_data1 = wd1; rd_en1 = re1;
    @(posedge clk);
    #1;
    wr_en0 = 1'b0; rd_en0 = 1'b0; clr0 = 1'b0;
    wr_en1 = 1'b0; rd_en1 = 1'b0;
  endtask

  task automatic cyc0(input logic we, input logic [7:0] wd, input logic re, input logic ce);
    cyc(we, wd, re, ce, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    int exp_c;
    rst_n = 1'b0;
    wr_en0 = 1'b0; rd_en0 = 1'b0; clr0 = 1'b0; wr_data0 = '0;
    wr_en1 = 1'b0; rd_en1 = 1'b0; clr1 = 1'b0; wr_data1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count0", 32'(count0), 32'd0);
    chk("rst_empty0", 32'(empty0), 32'd1);
    chk("rst_full0", 32'(full0), 32'd0);
    chk("rst_ae0", 32'(ae0), 32'd1);
    chk("rst_af0", 32'(af0), 32'd0);
    chk("rst_rdata0", 32'(rd_data0), 32'd0);
    chk("rst_ovf0", 32'(ovf0), 32'd0);
    chk("rst_unf0", 32'(unf0), 32'd0);
    chk("rst_count1", 32'(count1), 32'd0);
    #4 rst_n = 1'b1;

    // Fill both channels concurrently past their depths.
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1, 32'hCAFE0000 + 32'(i), 1'b0);
      exp_c = (i > 16) ? 16 : i;
      chk("fill_count0", 32'(count0), 32'(exp_c));
      chk("fill_full0", 32'(full0), 32'(exp_c == 16));
      chk("fill_ae0", 32'(ae0), 32'(exp_c <= 2));
      chk("fill_af0", 32'(af0), 32'(exp_c >= 14));
      chk("fill_ovf0", 32'(ovf0), 32'(i > 16));
      chk("fill_count1", 32'(count1), 32'((i > 4) ? 4 : i));
      chk("fill_full1", 32'(full1), 32'(i >= 4));
      chk("fill_ovf1", 32'(ovf1), 32'(i > 4));
    end

    // Drain: words 1..16 in order on ch0, words 1..4 on ch1.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 32'h0, i <= 4);
      chk("drain_data0", 32'(rd_data0), 32'(8'(8'h10 + i)));
      chk("drain_count0", 32'(count0), 32'(16 - i));
      if (i <= 4) chk("drain_data1", rd_data1, 32'hCAFE0000 + 32'(i));
    end
    chk("drain_empty0", 32'(empty0), 32'd1);
    chk("drain_empty1", 32'(empty1), 32'd1);
    chk("drain_unf0", 32'(unf0), 32'd0);
    cyc0(1'b0, 8'h0, 1'b0, 1'b1);
    chk("clr_ovf0", 32'(ovf0), 32'd0);
    chk("keep_ovf1", 32'(ovf1), 32'd1);

    // Underflow sequence.
    for (int i = 1; i <= 16; i++) cyc0(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) cyc0(1'b0, 8'h0, 1'b1, 1'b0);
    chk("uf_count", 32'(count0), 32'd1);
    chk("uf_empty", 32'(empty0), 32'd0);
    chk("uf_ae", 32'(ae0), 32'd1);
    cyc0(1'b0, 8'h0, 1'b1, 1'b0);
    chk("uf_last_data", 32'(rd_data0), 32'h000000C0);
    chk("uf_last_unf", 32'(unf0), 32'd0);
    cyc0(1'b0, 8'h0, 1'b1, 1'b0);
    chk("uf_unf_set", 32'(unf0), 32'd1);
    chk("uf_hold_data", 32'(rd_data0), 32'h000000C0);
    chk("uf_count0", 32'(count0), 32'd0);
    cyc0(1'b0, 8'h0, 1'b0, 1'b1);
    chk("uf_clr", 32'(unf0), 32'd0);

    // Simultaneous read/write at full, across pointer wrap.
    for (int i = 1; i <= 16; i++) cyc0(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc0(1'b1, 8'(8'h60 + k), 1'b1, 1'b0);
      chk("rw_full_data", 32'(rd_data0), 32'(8'(8'h40 + k)));
      chk("rw_full_count", 32'(count0), 32'd16);
      chk("rw_full_flag", 32'(full0), 32'd1);
      chk("rw_full_ovf", 32'(ovf0), 32'd0);
    end
    for (int i = 1; i <= 16; i++) begin
      cyc0(1'b0, 8'h0, 1'b1, 1'b0);
      chk("rw_drain_data", 32'(rd_data0), (i <= 12) ? 32'(8'(8'h44 + i)) : 32'(8'(8'h60 + i - 12)));
    end
    chk("rw_drain_empty", 32'(empty0), 32'd1);

    // Simultaneous read/write at empty: write accepted, read rejected.
    cyc0(1'b1, 8'h77, 1'b1, 1'b0);
    chk("rw_empty_count", 32'(count0), 32'd1);
    chk("rw_empty_unf", 32'(unf0), 32'd1);
    chk("rw_empty_hold", 32'(rd_data0), 32'h00000064);
    cyc0(1'b0, 8'h0, 1'b1, 1'b1);
    chk("rw_empty_data", 32'(rd_data0), 32'h00000077);
    chk("rw_empty_clr", 32'(unf0), 32'd0);

    // Asynchronous reset mid-operation.
    for (int i = 1; i <= 9; i++) cyc0(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count0), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count0), 32'd0);
    chk("async_rst_empty", 32'(empty0), 32'd1);
    chk("async_rst_rdata", 32'(rd_data0), 32'd0);
    chk("async_rst_ovf1", 32'(ovf1), 32'd0);
    #1 rst_n = 1'b1;
    cyc0(1'b1, 8'h5A, 1'b0, 1'b0);
    cyc0(1'b0, 8'h0, 1'b1, 1'b0);
    chk("post_rst_data", 32'(rd_data0), 32'h0000005A);
    chk("post_rst_empty", 32'(empty0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
